// File: rtl/bwt_pkg.sv
// Shared BWT constants and the inverse-BWT decoder state encoding.
package bwt_pkg;

   localparam int          N_DEF    = 8;
   localparam int          W_DEF    = 8;
   localparam logic [7:0]  SENTINEL = 8'h24;  // '$'

   typedef enum logic [1:0] {IDLE, RANK, WALK, DONE} ibwt_state_t;

endpackage

// File: rtl/ibwt_lf_rank.sv
// Combinational LF-mapping rank for one row: characters strictly smaller than
// L[p] plus equal characters in earlier rows.
module ibwt_lf_rank #(
   parameter  int N  = 8,
   parameter  int W  = 8,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0][W-1:0] l,
   input  logic [IW-1:0]       p,
   output logic [IW-1:0]       lf
);

   logic [W-1:0] key;
   logic [N-1:0] lt_vec;
   logic [N-1:0] eq_vec;

   assign key = l[p];

   for (genvar j = 0; j < N; j++) begin : g_cmp
      assign lt_vec[j] = (l[j] < key);
      assign eq_vec[j] = (l[j] == key) && (IW'(j) < p);
   end

   // Total never exceeds N-1, so IW bits cannot overflow.
   always_comb begin
      lf = '0;
      for (int j = 0; j < N; j++) begin
         lf = lf + IW'(lt_vec[j]) + IW'(eq_vec[j]);
      end
   end

endmodule

// File: rtl/ibwt_decoder.sv
// Inverse BWT: RANK builds the LF table one row per cycle, WALK follows it.
// Optional sentinel-count check enabled by defining IBWT_SENTINEL_CHECK_EN.
module ibwt_decoder
   import bwt_pkg::*;
#(
   parameter  int N  = N_DEF,
   parameter  int W  = W_DEF,
   localparam int IW = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_decode,
   input  logic [N-1:0][W-1:0] bwt_string,
   output logic [N-1:0][W-1:0] output_string,
   output logic               busy,
   output logic               done,
   output logic               error
);

   localparam logic [W-1:0] SENT = W'(SENTINEL);

   ibwt_state_t             state_q, state_d;
   logic [N-1:0][W-1:0]     l_q, l_d;
   logic [N-1:0][IW-1:0]    lf_q, lf_d;
   logic [N-1:0][W-1:0]     out_q, out_d;
   logic [IW-1:0]           p_q, p_d;
   logic [IW-1:0]           row_q, row_d;
   logic [IW-1:0]           k_q, k_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [IW-1:0]           lf_row;

`ifdef IBWT_SENTINEL_CHECK_EN
   localparam int CW = $clog2(N + 1);
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    error_q, error_d;
   assign error = error_q;
`else
   assign error = 1'b0;
`endif

   ibwt_lf_rank #(.N(N), .W(W)) u_rank (
      .l  (l_q),
      .p  (p_q),
      .lf (lf_row)
   );

   always_comb begin
      state_d = state_q;
      l_d     = l_q;
      lf_d    = lf_q;
      out_d   = out_q;
      p_d     = p_q;
      row_d   = row_q;
      k_d     = k_q;
      // Status outputs lag the state by one edge.
      busy_d  = (state_q == RANK) || (state_q == WALK);
      done_d  = (state_q == DONE);
`ifdef IBWT_SENTINEL_CHECK_EN
      cnt_d   = cnt_q;
      error_d = error_q;
`endif
      case (state_q)
         IDLE: begin
            if (start_decode) begin
               for (int p = 0; p < N; p++) l_d[p] = bwt_string[N-1-p];
               p_d     = '0;
               state_d = RANK;
`ifdef IBWT_SENTINEL_CHECK_EN
               cnt_d   = '0;
               error_d = 1'b0;
`endif
            end
         end
         RANK: begin
            lf_d[p_q] = lf_row;
`ifdef IBWT_SENTINEL_CHECK_EN
            cnt_d = cnt_q + CW'(l_q[p_q] == SENT);
`endif
            if (p_q == IW'(N - 1)) begin
               state_d  = WALK;
               row_d    = '0;
               k_d      = IW'(N - 2);
               out_d[0] = SENT;
`ifdef IBWT_SENTINEL_CHECK_EN
               if (cnt_d != CW'(1)) begin
                  state_d = DONE;
                  error_d = 1'b1;
                  out_d   = '0;
               end
`endif
            end else begin
               p_d = p_q + 1'b1;
            end
         end
         WALK: begin
            out_d[IW'(N - 1) - k_q] = l_q[row_q];
            row_d = lf_q[row_q];
            if (k_q == '0) state_d = DONE;
            else           k_d     = k_q - 1'b1;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         l_q     <= '0;
         lf_q    <= '0;
         out_q   <= '0;
         p_q     <= '0;
         row_q   <= '0;
         k_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         l_q     <= l_d;
         lf_q    <= lf_d;
         out_q   <= out_d;
         p_q     <= p_d;
         row_q   <= row_d;
         k_q     <= k_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef IBWT_SENTINEL_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         error_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         error_q <= error_d;
      end
   end
`endif

   assign output_string = out_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_ibwt_decoder.sv
// Directed bench for ibwt_decoder; expected results queued at start, checked at done.
module tb_ibwt_decoder;

   localparam int N = 8;
   localparam int W = 8;

   typedef struct {
      logic [N*W-1:0] out;
      logic           err;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                start_decode;
   logic [N-1:0][W-1:0] bwt_string;
   logic [N-1:0][W-1:0] output_string;
   logic                busy, done, error;

   exp_t sb[$];
   int   errs   = 0;
   int   checks = 0;

   ibwt_decoder #(.N(N), .W(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .start_decode  (start_decode),
      .bwt_string    (bwt_string),
      .output_string (output_string),
      .busy          (busy),
      .done          (done),
      .error         (error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Start at edge 0, optional second start at edge restart_at, watch 40 cycles.
   task automatic decode(input string tag, input logic [63:0] bwt, input logic [63:0] eo,
                         input logic ee, input int lat, input int restart_at);
      exp_t e;
      int   busy_n  = 0;
      int   done_n  = 0;
      int   done_at = -1;
      e.out = eo;
      e.err = ee;
      sb.push_back(e);
      @(negedge clk);
      bwt_string   = bwt;
      start_decode = 1'b1;
      @(negedge clk);
      start_decode = 1'b0;
      bwt_string   = ~bwt;
      chk({tag, "_busy_c0"}, 64'(busy), 64'd0);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            if (done_at < 0) done_at = c;
            if (sb.size() == 0) begin
               chk({tag, "_sb_underflow"}, 64'd0, 64'd1);
            end else begin
               e = sb.pop_front();
               chk({tag, "_out"}, output_string, e.out);
               chk({tag, "_err"}, 64'(error), 64'(e.err));
            end
         end
         start_decode = (c + 1 == restart_at);
      end
      start_decode = 1'b0;
      chk({tag, "_done_cnt"}, 64'(done_n), 64'd1);
      chk({tag, "_done_lat"}, 64'(done_at), 64'(lat));
      chk({tag, "_busy_cnt"}, 64'(busy_n), 64'(lat - 1));
      chk({tag, "_hold"}, output_string, eo);
      chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   initial begin
      rst          = 1'b1;
      start_decode = 1'b0;
      bwt_string   = '0;
      #12;
      chk("rst_out",  output_string, 64'd0);
      chk("rst_busy", 64'(busy),  64'd0);
      chk("rst_done", 64'(done),  64'd0);
      chk("rst_err",  64'(error), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      decode("miss",    "ssm$ssii", "mississ$", 1'b0, 16, 0);
      decode("ordered", "g$abcdef", "abcdefg$", 1'b0, 16, 0);
      decode("repeat",  "aaaaaaa$", "aaaaaaa$", 1'b0, 16, 0);
      decode("busy_st", "ssm$ssii", "mississ$", 1'b0, 16, 5);

      // Abort in WALK: outputs drop asynchronously and no done follows.
      @(negedge clk);
      bwt_string   = "g$abcdef";
      start_decode = 1'b1;
      @(negedge clk);
      start_decode = 1'b0;
      repeat (12) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_out",  output_string, 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) begin
         @(negedge clk);
         chk("mid_rst_nodone", 64'(done), 64'd0);
      end
      decode("after_rst", "ssm$ssii", "mississ$", 1'b0, 16, 0);

`ifdef IBWT_SENTINEL_CHECK_EN
      decode("no_sent",  "ssmsssii", 64'd0, 1'b1, 9, 0);
      chk("no_sent_err_hold", 64'(error), 64'd1);
      decode("two_sent", "ss$$ssii", 64'd0, 1'b1, 9, 0);
      decode("recover",  "g$abcdef", "abcdefg$", 1'b0, 16, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/ibwt_decoder.md
Name: ibwt_decoder

Overview:
- Inverse Burrows-Wheeler transform. It takes the N-character BWT last column produced by MM_top and reconstructs the original sentinel-terminated string.
- It is the decode end of the BWT path and sits after MM_top's output_string, with the same array ordering.
- It works in two sequential phases: RANK builds the LF-mapping table, one row per cycle; WALK follows the LF chain, emitting one character per cycle.

Parameters:
- N, 8, string length including the sentinel (≥2). Localparam IW = $clog2(N) is the row-index width.
- W, 8, character width in bits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start_decode  input  1  one-cycle request; sampled only in IDLE
- bwt_string  input  [W-1:0] x [N-1:0]  BWT last column. Element [N-1] is row 0; element [N-1-p] is row p.
- output_string  output  [W-1:0] x [N-1:0]  decoded string. Element [N-1] is the first character; element [0] is the sentinel.
- busy  output  1  high while in RANK or WALK
- done  output  1  one-cycle pulse when output_string is valid
- error  output  1  sentinel-count fault flag; see Optional Feature

Behaviour:
- Reset (async, active-high):
  - state=IDLE; output_string all 0; busy=0; done=0; error=0.
  - Internal L/LF tables cleared.
  - A reset in any state aborts the decode immediately; no done pulse follows.
- IDLE:
  - On start_decode=1, bwt_string is latched into internal L[0..N-1] (row order).
  - Row counter p=0; state→RANK. busy rises on the next edge.
- RANK (N cycles, p=0..N-1):
  - LF[p] = count(j: L[j] < L[p]) + count(j < p: L[j] == L[p]). Unsigned compare, result IW bits.
  - Computed combinationally by the rank sub-module and registered.
  - After p=N-1, state→WALK, with row=0 and k=N-2.
  - Row 0 begins with the sentinel, which must be the unique minimum character.
- WALK (N-1 cycles):
  - Each cycle: out position k ← L[row]; row ← LF[row]; k decrements.
  - Position k maps to output_string element [N-1-k].
  - Position N-1 (element [0]) is written with SENTINEL.
  - After k=0, state→DONE.
- DONE (1 cycle):
  - done=1, busy=0; state→IDLE.
  - output_string holds until the next accepted start or reset.
- Latency: start sampled at edge 0; done is high in the cycle after edge 2N. For N=8, that is 16 cycles.
- start_decode while busy or in DONE is ignored; no queueing.
- bwt_string changes after the start cycle have no effect.
- output_string is not cleared at start. It is updated element by element during WALK and is valid only when done=1.

Optional Feature:
- Macro: IBWT_SENTINEL_CHECK_EN
- Defined:
  - During RANK, count the characters equal to SENTINEL.
  - If the count is not 1, WALK is skipped: go RANK→DONE with error=1, and output_string is cleared to all 0.
  - error stays high until the next accepted start or reset.
- Not defined: no check; error is tied 0. Input without exactly one minimum-valued sentinel gives undefined output.

Decomposition:
- Package bwt_pkg:
  - SENTINEL = 8'h24 ('$').
  - typedef enum logic [1:0] {IDLE, RANK, WALK, DONE} ibwt_state_t.
  - Default N/W constants, shared with MM_top.
- Sub-module ibwt_lf_rank: combinational. Inputs are the L array and row index p; output is LF[p]. It uses N less-than and N equal comparators plus a popcount adder tree.

Test Plan:
- "mississ$" path: bwt_string = "ssm$ssii" (row 0 = 's' in element [7]), pulse start → done at cycle 16; output_string prints "mississ$"; busy high cycles 1–15.
- Ordered input: "g$abcdef" → "abcdefg$".
- Repeated characters: "aaaaaaa$" → "aaaaaaa$", which checks equal-character tie ordering in LF.
- Start while busy: pulse start again at cycle 5 → ignored; single done at cycle 16; result unchanged.
- Reset mid-operation: assert rst during WALK → outputs 0 and busy 0 on the same cycle. Restarting with "ssm$ssii" then decodes correctly.
- With IBWT_SENTINEL_CHECK_EN: "ssmsssii" (no '$') → done with error=1 and output_string all 0. "ss$$ssii" (two '$') → error=1. A following valid decode clears error.
